// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard detection / forwarding-control unit.
// Optional build macro: HAZARD_PERF_EN (stall-event performance counters).
package hazard_pkg;

    // Register-address width carried in each shadow record.
    localparam int REC_AW = 5;

    // Register 0 is hard-wired zero and never participates in forwarding or stalls.
    localparam logic [REC_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e_t;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memtoreg;
        logic [REC_AW-1:0] writereg;
        logic [REC_AW-1:0] rs;
        logic [REC_AW-1:0] rt;
    } stage_rec_t;

    localparam stage_rec_t REC_BUBBLE = '{
        valid:    1'b0,
        regwrite: 1'b0,
        memtoreg: 1'b0,
        writereg: 5'd0,
        rs:       5'd0,
        rt:       5'd0
    };

    // True when the stage record will write register r (r0 never matches).
    function automatic logic rec_match(input logic [REC_AW-1:0] r, input stage_rec_t s);
        return s.valid & s.regwrite & (s.writereg == r) & (r != REG_ZERO);
    endfunction

    // Execute-stage operand select: Memory producer is younger, so it wins over Writeback.
    function automatic fwd_e_t fwd_sel(input logic [REC_AW-1:0] r,
                                       input stage_rec_t m,
                                       input stage_rec_t w);
        fwd_e_t sel;
        if (rec_match(r, m)) begin
            sel = FWD_MEM;
        end else if (rec_match(r, w)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline record with async clear and a synchronous bubble insert.
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_bubble,
    input  stage_rec_t i_d,
    output stage_rec_t o_q
);

    stage_rec_t r_q;

    // Capture the upstream record each cycle, or an all-zero bubble when requested.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= REC_BUBBLE;
        end else if (i_bubble) begin
            r_q <= REC_BUBBLE;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
// Shadows E/M/W destination info; drives Decode/Execute forward selects and stalls.
// Optional build macro: HAZARD_PERF_EN enables the stall-event counters;
// without it both counter ports read as zero.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,   // must equal REC_AW in hazard_pkg
    parameter int CNT_W  = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              UsesRsD,
    input  logic              UsesRtD,
    input  logic              BranchD,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic [REG_AW-1:0] WriteRegD,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  LwStallCnt,
    output logic [CNT_W-1:0]  BrStallCnt
);

    stage_rec_t w_d_rec;
    stage_rec_t w_e;
    stage_rec_t w_m;
    stage_rec_t w_w;
    logic       w_lwstall;
    logic       w_brstall;
    logic       w_stall;
    fwd_e_t     w_fwd_ae;
    fwd_e_t     w_fwd_be;
    logic       w_unused_bits;

    // Pack the Decode instruction into the record that enters Execute.
    always_comb begin
        w_d_rec          = REC_BUBBLE;
        w_d_rec.valid    = 1'b1;
        w_d_rec.regwrite = RegWriteD;
        w_d_rec.memtoreg = MemtoRegD;
        w_d_rec.writereg = WriteRegD;
        w_d_rec.rs       = RsD;
        w_d_rec.rt       = RtD;
    end

    // E takes a bubble while Decode is held; M and W simply follow.
    hazard_stage_reg u_stage_e (.clk(clk), .reset(reset), .i_bubble(w_stall), .i_d(w_d_rec), .o_q(w_e));
    hazard_stage_reg u_stage_m (.clk(clk), .reset(reset), .i_bubble(1'b0),    .i_d(w_e),     .o_q(w_m));
    hazard_stage_reg u_stage_w (.clk(clk), .reset(reset), .i_bubble(1'b0),    .i_d(w_m),     .o_q(w_w));

    // Source fields of the older records are never consulted.
    assign w_unused_bits = ^{w_m.rs, w_m.rt, w_w.rs, w_w.rt, w_w.memtoreg};

    // Load-use and branch-compare stall detection against the shadow records.
    always_comb begin
        w_lwstall = w_e.memtoreg &
                    ((UsesRsD & rec_match(RsD, w_e)) | (UsesRtD & rec_match(RtD, w_e)));
        w_brstall = BranchD &
                    ((UsesRsD & (rec_match(RsD, w_e) | (w_m.memtoreg & rec_match(RsD, w_m)))) |
                     (UsesRtD & (rec_match(RtD, w_e) | (w_m.memtoreg & rec_match(RtD, w_m)))));
        w_stall   = w_lwstall | w_brstall;
    end

    // Forward selects: Decode compare reads ALUOutM only (loads are not ready in M).
    always_comb begin
        w_fwd_ae  = fwd_sel(w_e.rs, w_m, w_w);
        w_fwd_be  = fwd_sel(w_e.rt, w_m, w_w);
        ForwardAD = rec_match(RsD, w_m) & ~w_m.memtoreg;
        ForwardBD = rec_match(RtD, w_m) & ~w_m.memtoreg;
        ForwardAE = w_fwd_ae;
        ForwardBE = w_fwd_be;
        StallF    = w_stall;
        StallD    = w_stall;
        FlushE    = w_stall;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_lw_cnt;
    logic [CNT_W-1:0] r_br_cnt;

    // Count stall cycles; a cycle that is both kinds is charged to load-use only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lw_cnt <= {CNT_W{1'b0}};
            r_br_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_lwstall) begin
                r_lw_cnt <= r_lw_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_lw_cnt <= r_lw_cnt;
            end
            if (w_brstall & ~w_lwstall) begin
                r_br_cnt <= r_br_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_br_cnt <= r_br_cnt;
            end
        end
    end

    assign LwStallCnt = r_lw_cnt;
    assign BrStallCnt = r_br_cnt;
`else
    assign LwStallCnt = {CNT_W{1'b0}};
    assign BrStallCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenario table, a reset
// corner sequence, and randomized traffic against a pipeline-level model.
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  RsD, RtD, WriteRegD;
    logic        UsesRsD, UsesRtD, BranchD, RegWriteD, MemtoRegD;
    logic        ForwardAD, ForwardBD, StallF, StallD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] LwStallCnt, BrStallCnt;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_fwd_unit #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .UsesRsD(UsesRsD), .UsesRtD(UsesRtD),
        .BranchD(BranchD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .WriteRegD(WriteRegD),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .LwStallCnt(LwStallCnt), .BrStallCnt(BrStallCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        bit urs, urt, br, rw, mr;
        logic [4:0] wr;
        bit fad, fbd;
        logic [1:0] fae, fbe;
        bit lw, brs;   // expected stall kind this cycle (brs = branch stall not caused by load-use)
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(int rs, int rt, bit urs, bit urt, bit br, bit rw, bit mr, int wr,
                                bit fad, bit fbd, int fae, int fbe, bit lw, bit brs);
        vec_t v;
        v.rs = rs[4:0]; v.rt = rt[4:0]; v.urs = urs; v.urt = urt; v.br = br;
        v.rw = rw; v.mr = mr; v.wr = wr[4:0];
        v.fad = fad; v.fbd = fbd; v.fae = fae[1:0]; v.fbe = fbe[1:0];
        v.lw = lw; v.brs = brs;
        return v;
    endfunction

    // Pipeline model: slot 0 = Execute, 1 = Memory, 2 = Writeback.
    typedef struct {
        bit v, rw, mr;
        int wr, rs, rt;
    } instr_t;

    instr_t pipe[3];
    int     m_lw_cnt, m_br_cnt;

    function automatic bit hits(int r, int s);
        return pipe[s].v && pipe[s].rw && (pipe[s].wr == r) && (r != 0);
    endfunction

    function automatic int fwd_of(int r);
        if (hits(r, 1)) return 2;
        if (hits(r, 2)) return 1;
        return 0;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 3; s++) pipe[s] = '{v:0, rw:0, mr:0, wr:0, rs:0, rt:0};
        m_lw_cnt = 0;
        m_br_cnt = 0;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic check_all(input string tag, input bit fad, input bit fbd,
                             input logic [1:0] fae, input logic [1:0] fbe, input bit stall,
                             input int lwc, input int brc);
        cmp({tag, ".StallF"}, {31'd0, StallF}, {31'd0, stall});
        cmp({tag, ".StallD"}, {31'd0, StallD}, {31'd0, stall});
        cmp({tag, ".FlushE"}, {31'd0, FlushE}, {31'd0, stall});
        cmp({tag, ".ForwardAD"}, {31'd0, ForwardAD}, {31'd0, fad});
        cmp({tag, ".ForwardBD"}, {31'd0, ForwardBD}, {31'd0, fbd});
        cmp({tag, ".ForwardAE"}, {30'd0, ForwardAE}, {30'd0, fae});
        cmp({tag, ".ForwardBE"}, {30'd0, ForwardBE}, {30'd0, fbe});
`ifdef HAZARD_PERF_EN
        cmp({tag, ".LwStallCnt"}, LwStallCnt, lwc);
        cmp({tag, ".BrStallCnt"}, BrStallCnt, brc);
`else
        cmp({tag, ".LwStallCnt"}, LwStallCnt, 32'd0);
        cmp({tag, ".BrStallCnt"}, BrStallCnt, 32'd0);
`endif
    endtask

    task automatic drive(input vec_t v);
        RsD = v.rs; RtD = v.rt; UsesRsD = v.urs; UsesRtD = v.urt; BranchD = v.br;
        RegWriteD = v.rw; MemtoRegD = v.mr; WriteRegD = v.wr;
    endtask

    initial begin
        int   lw_acc, br_acc;
        vec_t rv;
        bit   e_lw, e_br, e_fad, e_fbd;
        int   e_fae, e_fbe;

        // rows: rs,rt,urs,urt,br,rw,mr,wr | fad,fbd,fae,fbe,lw,brs
        tbl[0]  = mk( 1, 2,1,1,0,1,0, 3, 0,0,0,0,0,0);  // add r3
        tbl[1]  = mk( 3, 9,1,1,0,1,0, 8, 0,0,0,0,0,0);  // add r8 <- r3
        tbl[2]  = mk(10,11,1,1,0,1,0,12, 0,0,2,0,0,0);  // r3 from M
        tbl[3]  = mk( 8, 0,1,1,0,1,0,12, 1,0,0,0,0,0);  // reads r8 (in M)
        tbl[4]  = mk(20,21,1,1,0,1,0,12, 0,0,1,0,0,0);  // r8 from W (one between)
        tbl[5]  = mk(12,12,1,1,0,1,0,18, 1,1,0,0,0,0);
        tbl[6]  = mk( 0, 0,0,0,0,0,0, 0, 0,0,2,2,0,0);  // r12 in M and W: M wins
        tbl[7]  = mk( 1, 2,1,1,0,1,0, 0, 0,0,0,0,0,0);  // write r0
        tbl[8]  = mk( 3, 4,1,1,0,1,1, 0, 0,0,0,0,0,0);  // load into r0
        tbl[9]  = mk( 0, 0,1,1,0,0,0, 0, 0,0,0,0,0,0);  // read r0 behind load r0
        tbl[10] = mk( 0, 0,1,1,1,0,0, 0, 0,0,0,0,0,0);  // branch on r0
        tbl[11] = mk( 0, 0,1,1,0,1,0,19, 0,0,0,0,0,0);
        tbl[12] = mk( 0, 0,0,0,0,0,0, 0, 0,0,0,0,0,0);
        tbl[13] = mk( 1, 0,1,0,0,1,1, 5, 0,0,0,0,0,0);  // lw r5
        tbl[14] = mk( 5, 2,1,1,0,1,0, 6, 0,0,0,0,1,0);  // sub r6,r5,r2: stall
        tbl[15] = mk( 5, 2,1,1,0,1,0, 6, 0,0,0,0,0,0);  // held, advances
        tbl[16] = mk( 0, 0,0,0,0,0,0, 0, 0,0,1,0,0,0);  // sub in E: r5 from W
        tbl[17] = mk( 1, 2,1,1,0,1,0, 4, 0,0,0,0,0,0);  // add r4
        tbl[18] = mk( 4, 0,1,1,1,0,0, 0, 0,0,0,0,0,1);  // beq r4,r0: stall
        tbl[19] = mk( 4, 0,1,1,1,0,0, 0, 1,0,0,0,0,0);  // forward from M
        tbl[20] = mk( 2, 0,1,0,0,1,1, 7, 0,0,1,0,0,0);  // lw r7
        tbl[21] = mk( 7, 1,1,1,1,0,0, 0, 0,0,0,0,1,0);  // beq r7,r1 stall 1
        tbl[22] = mk( 7, 1,1,1,1,0,0, 0, 0,0,0,0,0,1);  // stall 2
        tbl[23] = mk( 7, 1,1,1,1,0,0, 0, 0,0,0,0,0,0);  // read from RF
        tbl[24] = mk( 0, 0,0,0,0,0,0, 0, 0,0,0,0,0,0);

        // Reset state
        reset = 1'b1;
        drive(tbl[14]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 0, 0, 2'd0, 2'd0, 0, 0, 0);
        reset = 1'b0;

        // Directed scenario table
        lw_acc = 0; br_acc = 0;
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i]);
            #1;
            check_all($sformatf("tbl%0d", i), tbl[i].fad, tbl[i].fbd, tbl[i].fae, tbl[i].fbe,
                      tbl[i].lw | tbl[i].brs, lw_acc, br_acc);
            lw_acc += int'(tbl[i].lw);
            br_acc += int'(tbl[i].brs);
            @(negedge clk);
        end

        // Reset asserted while a load-use stall is pending
        drive(tbl[13]);
        @(negedge clk);
        drive(tbl[14]);
        #1;
        cmp("midrst.pre_stall", {31'd0, StallF}, 32'd1);
        reset = 1'b1;
        #1;
        check_all("midrst.during", 0, 0, 2'd0, 2'd0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("midrst.after", 0, 0, 2'd0, 2'd0, 0, 0, 0);
        @(negedge clk);

        // Randomized traffic against the model, from a fresh reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 400; i++) begin
            rv.rs = 5'($urandom_range(0, 7));
            rv.rt = 5'($urandom_range(0, 7));
            rv.wr = 5'($urandom_range(0, 7));
            rv.urs = 1'($urandom_range(0, 1));
            rv.urt = 1'($urandom_range(0, 1));
            rv.br  = ($urandom_range(0, 3) == 0);
            rv.rw  = ($urandom_range(0, 3) != 0);
            rv.mr  = rv.rw && ($urandom_range(0, 2) == 0);
            drive(rv);
            #1;
            e_lw  = pipe[0].mr && ((rv.urs && hits(rv.rs, 0)) || (rv.urt && hits(rv.rt, 0)));
            e_br  = rv.br &&
                    ((rv.urs && (hits(rv.rs, 0) || (pipe[1].mr && hits(rv.rs, 1)))) ||
                     (rv.urt && (hits(rv.rt, 0) || (pipe[1].mr && hits(rv.rt, 1)))));
            e_fad = hits(rv.rs, 1) && !pipe[1].mr;
            e_fbd = hits(rv.rt, 1) && !pipe[1].mr;
            e_fae = fwd_of(pipe[0].rs);
            e_fbe = fwd_of(pipe[0].rt);
            check_all($sformatf("rnd%0d", i), e_fad, e_fbd, e_fae[1:0], e_fbe[1:0],
                      e_lw || e_br, m_lw_cnt, m_br_cnt);
            if (e_lw) m_lw_cnt++;
            else if (e_br) m_br_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (e_lw || e_br) pipe[0] = '{v:0, rw:0, mr:0, wr:0, rs:0, rt:0};
            else pipe[0] = '{v:1, rw:rv.rw, mr:rv.mr, wr:int'(rv.wr), rs:int'(rv.rs), rt:int'(rv.rt)};
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
